// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 opcode encodings, sequencer state encodings and operand-sign helpers.
package muldiv_pkg;

  localparam int unsigned MULDIV_W = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } m_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Divide-class ops live in the upper half of the funct3 space
  function automatic logic op_is_div(input m_op_t op);
    return op[2];
  endfunction

  // rs1 is signed for everything except the fully unsigned variants
  function automatic logic op_a_signed(input m_op_t op);
    return !(op == F3_MULHU || op == F3_DIVU || op == F3_REMU);
  endfunction

  // rs2 is signed only for MUL, MULH, DIV and REM
  function automatic logic op_b_signed(input m_op_t op);
    return (op == F3_MUL || op == F3_MULH || op == F3_DIV || op == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Datapath of the iterative multiply/divide unit.
// Holds a 2W accumulator ({high, low}) and a W-bit operand register and performs one
// shift-add (multiply) or restoring shift-subtract (divide) iteration per i_step.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   i_init     load accumulator with {0, i_a_mag} and operand register with i_b_mag
//   i_step     advance one iteration
//   i_div      1 = divide iteration, 0 = multiply iteration
//   i_neg      negate the final value (2W for multiply, selected word for divide)
//   i_sel_hi   select the high word (MULH*, REM*) instead of the low word
//   o_res_c    combinational result taken from the post-step accumulator value
module muldiv_core #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_init,
  input  logic                  i_step,
  input  logic                  i_div,
  input  logic                  i_neg,
  input  logic                  i_sel_hi,
  input  logic [DATA_WIDTH-1:0] i_a_mag,
  input  logic [DATA_WIDTH-1:0] i_b_mag,
  output logic [DATA_WIDTH-1:0] o_res_c
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned W2 = 2 * DATA_WIDTH;

  logic [W2-1:0] r_acc;
  logic [W-1:0]  r_opb;

  logic [W-1:0]  w_hi;
  logic [W-1:0]  w_lo;
  logic [W:0]    w_mul_sum;
  logic [W2-1:0] w_mul_nxt;
  logic [W:0]    w_rem_sh;
  logic [W:0]    w_diff;
  logic          w_fits;
  logic [W2-1:0] w_div_nxt;
  logic [W2-1:0] w_acc_nxt;
  logic [W2-1:0] w_full;
  logic [W-1:0]  w_word;

  assign w_hi = r_acc[W2-1:W];
  assign w_lo = r_acc[W-1:0];

  // Multiply: add multiplicand into the high half when the multiplier LSB is set, then shift right
  assign w_mul_sum = {1'b0, w_hi} + (r_acc[0] ? {1'b0, r_opb} : (W+1)'(0));
  assign w_mul_nxt = {w_mul_sum, w_lo[W-1:1]};

  // Divide: shift the next dividend bit into the partial remainder, subtract if it fits
  assign w_rem_sh  = {w_hi, w_lo[W-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_opb};
  assign w_fits    = (w_rem_sh >= {1'b0, r_opb});
  assign w_div_nxt = {(w_fits ? w_diff[W-1:0] : w_rem_sh[W-1:0]), w_lo[W-2:0], w_fits};

  assign w_acc_nxt = i_div ? w_div_nxt : w_mul_nxt;

  // Product sign applies to the full 2W value; quotient/remainder signs apply per word
  always_comb begin
    w_full  = (i_neg && !i_div) ? (W2'(0) - w_acc_nxt) : w_acc_nxt;
    w_word  = i_sel_hi ? w_full[W2-1:W] : w_full[W-1:0];
    o_res_c = (i_neg && i_div) ? (W'(0) - w_word) : w_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_opb <= '0;
    end else if (i_init) begin
      r_acc <= {W'(0), i_a_mag};
      r_opb <= i_b_mag;
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Accepts one M-op, stalls the front of the pipeline via busy while the
// 1-bit-per-cycle engine runs, then presents the result with a one-cycle done pulse.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start_e           M-op valid in E
//   funct3_e          operation select
//   src_a_e, src_b_e  rs1 / rs2 operands
//   flush_e           redirect flush, cancels the op in E
//   busy              stall request (combinational)
//   done              one-cycle result-valid pulse
//   result            final value, held until the next done
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MULDIV_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_e,
  input  logic [2:0]            funct3_e,
  input  logic [DATA_WIDTH-1:0] src_a_e,
  input  logic [DATA_WIDTH-1:0] src_b_e,
  input  logic                  flush_e,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  m_op_t            r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic [W-1:0]     r_result;

  m_op_t            w_op;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [W-1:0]     w_a_mag;
  logic [W-1:0]     w_b_mag;
  logic             w_neg;
  logic             w_div0;
  logic             w_ovf;
  logic             w_special;
  logic [W-1:0]     w_special_res;
  logic             w_accept;
  logic             w_init;
  logic             w_step;
  logic             w_res_ld;
  logic [W-1:0]     w_res_nxt;
  logic             w_sel_hi;
  logic [W-1:0]     w_core_res;

  // Operand decode: magnitudes and final-result sign
  assign w_op     = m_op_t'(funct3_e);
  assign w_a_neg  = op_a_signed(w_op) & src_a_e[W-1];
  assign w_b_neg  = op_b_signed(w_op) & src_b_e[W-1];
  assign w_a_mag  = w_a_neg ? (W'(0) - src_a_e) : src_a_e;
  assign w_b_mag  = w_b_neg ? (W'(0) - src_b_e) : src_b_e;
  // Remainder follows the dividend; product and quotient follow the operand sign XOR
  assign w_neg    = (w_op == F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  // Divide-by-zero and signed overflow resolve without iterating
  assign w_div0    = op_is_div(w_op) && (src_b_e == '0);
  assign w_ovf     = (w_op == F3_DIV || w_op == F3_REM) &&
                     (src_a_e == MIN_NEG) && (src_b_e == '1);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = w_op[1] ? src_a_e : '1;
    end else begin
      w_special_res = w_op[1] ? '0 : MIN_NEG;
    end
  end

  assign w_accept = start_e & ~flush_e;

  // MUL and DIV/DIVU take the low word; MULH* and REM* the high word
  assign w_sel_hi = r_op[2] ? r_op[1] : (r_op[1:0] != 2'b00);

  muldiv_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_init   (w_init),
    .i_step   (w_step),
    .i_div    (r_op[2]),
    .i_neg    (r_neg),
    .i_sel_hi (w_sel_hi),
    .i_a_mag  (w_a_mag),
    .i_b_mag  (w_b_mag),
    .o_res_c  (w_core_res)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_init      = 1'b0;
    w_step      = 1'b0;
    w_res_ld    = 1'b0;
    w_res_nxt   = r_result;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          busy = 1'b1;
          if (w_special) begin
            w_state_nxt = S_DONE;
            w_res_ld    = 1'b1;
            w_res_nxt   = w_special_res;
          end else begin
            w_state_nxt = S_CALC;
            w_init      = 1'b1;
          end
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (flush_e) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == '0) begin
            w_state_nxt = S_DONE;
            w_res_ld    = 1'b1;
            w_res_nxt   = w_core_res;
          end
        end
      end
      S_DONE: begin
        // A start_e seen here is the same stalled instruction
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Op context, iteration counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= F3_MUL;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_op  <= w_op;
        r_neg <= w_neg;
      end
      if (w_init) begin
        r_cnt <= CNT_W'(DATA_WIDTH - 1);
      end else if (w_step) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_res_ld) begin
        r_result <= w_res_nxt;
      end
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start_e;
  logic [2:0]  funct3_e;
  logic [31:0] src_a_e;
  logic [31:0] src_b_e;
  logic        flush_e;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_errors;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  muldiv_seq #(
    .DATA_WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_e  (start_e),
    .funct3_e (funct3_e),
    .src_a_e  (src_a_e),
    .src_b_e  (src_b_e),
    .flush_e  (flush_e),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, hold start_e like a stalled E stage until after the DONE cycle,
  // then check result, latency, busy-cycle count and the quiet cycle afterwards.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    int bc;
    @(negedge clk);
    start_e  = 1'b1;
    funct3_e = f;
    src_a_e  = a;
    src_b_e  = b;
    #1;
    bc = busy ? 1 : 0;
    n  = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (busy) bc++;
    end while (!done && n < 100);
    check({tag, " result"}, result, exp);
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " busy_cycles"}, 32'(bc), 32'(lat));
    @(posedge clk);
    #1 start_e = 1'b0;
    @(negedge clk);
    check({tag, " idle_after"}, {30'b0, busy, done}, 32'd0);
    check({tag, " hold"}, result, exp);
  endtask

  initial begin
    int ndone;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start_e  = 1'b0;
    funct3_e = 3'b000;
    src_a_e  = 32'd0;
    src_b_e  = 32'd0;
    flush_e  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, 30'b0}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    // Multiply
    run_op("mul_7_m3",      OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mul_shift",     OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);
    run_op("mulhu_max",     OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu_max",    OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("mulh_m1_m1",    OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulh_min_min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);

    // Divide
    run_op("div_m7_2",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",      OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("div_20_m3",     OP_DIV,    32'd20,       32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
    run_op("rem_20_m3",     OP_REM,    32'd20,       32'hFFFF_FFFD, 32'd2,        33);
    run_op("divu_100_7",    OP_DIVU,   32'd100,      32'd7,         32'd14,       33);
    run_op("remu_100_7",    OP_REMU,   32'd100,      32'd7,         32'd2,        33);

    // Special cases resolve in one cycle
    run_op("divu_by0",      OP_DIVU,   32'd9,        32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_by0",       OP_REM,    32'd5,        32'd0,         32'd5,        1);
    run_op("div_ovf",       OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",       OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);

    // Flush in CALC at T+10 cancels the op
    run_op("pre_flush",     OP_MUL,    32'd6,        32'd7,         32'd42,       33);
    @(negedge clk);
    start_e  = 1'b1;
    funct3_e = OP_DIVU;
    src_a_e  = 32'd100;
    src_b_e  = 32'd7;
    ndone    = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
    end
    check("flush_busy_t10", {31'b0, busy}, 32'd1);
    flush_e = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (done) ndone++;
    check("flush_busy_t11", {31'b0, busy}, 32'd0);
    check("flush_no_done", 32'(ndone), 32'd0);
    check("flush_result_kept", result, 32'd42);
    flush_e = 1'b0;
    start_e = 1'b0;
    run_op("after_flush",   OP_MUL,    32'd11,       32'd13,        32'd143,      33);

    // Reset mid-op at T+5
    @(negedge clk);
    start_e  = 1'b1;
    funct3_e = OP_MUL;
    src_a_e  = 32'd3;
    src_b_e  = 32'd5;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst     = 1'b1;
    start_e = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_outputs", {busy, done, 30'b0}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    rst   = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("rst_no_late_done", 32'(ndone), 32'd0);

    // Back-to-back: start held through DONE is ignored, next start runs full length
    run_op("b2b_first",     OP_MULHU,  32'h0001_0000, 32'h0001_0000, 32'd1,        33);
    run_op("b2b_second",    OP_REMU,   32'd1000,     32'd33,        32'd10,       33);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
